// File: rtl/id_forward_scoreboard.sv
// ID-stage hazard unit: shift scoreboard of in-flight writes, load-use stall and operand forwarding.
// Optional event counters are built only when ID_FORWARD_STATS_EN is defined.
module id_forward_scoreboard #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned REG_ADDR_WIDTH   = 5,
   parameter int unsigned PIPE_DEPTH       = 3,
   parameter int unsigned LOAD_READY_STAGE = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                id_valid,
   input  logic                                id_uses_rs,
   input  logic                                id_uses_rt,
   input  logic [REG_ADDR_WIDTH-1:0]           id_rs,
   input  logic [REG_ADDR_WIDTH-1:0]           id_rt,
   input  logic                                id_write_reg,
   input  logic [REG_ADDR_WIDTH-1:0]           id_write_addr,
   input  logic                                id_is_load,
   input  logic [DATA_WIDTH-1:0]               rf_rs_data,
   input  logic [DATA_WIDTH-1:0]               rf_rt_data,
   input  logic [PIPE_DEPTH*DATA_WIDTH-1:0]    stage_result,
   output logic                                stall,
   output logic [DATA_WIDTH-1:0]               rs_value,
   output logic [DATA_WIDTH-1:0]               rt_value,
   output logic [$clog2(PIPE_DEPTH+1)-1:0]     rs_fwd_sel,
   output logic [$clog2(PIPE_DEPTH+1)-1:0]     rt_fwd_sel,
   output logic [31:0]                         stall_count,
   output logic [31:0]                         fwd_count
);

   localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);

   // Index i holds the instruction currently in stage i+1.
   logic [PIPE_DEPTH-1:0]                     ent_valid_q, ent_valid_d;
   logic [PIPE_DEPTH-1:0][REG_ADDR_WIDTH-1:0] ent_addr_q,  ent_addr_d;
   logic [PIPE_DEPTH-1:0]                     ent_load_q,  ent_load_d;

   logic rs_req_c, rt_req_c;
   logic rs_stall_c, rt_stall_c;

   assign rs_req_c = id_valid && id_uses_rs && (id_rs != '0);
   assign rt_req_c = id_valid && id_uses_rt && (id_rt != '0);

   // Scan oldest to youngest so the lowest matching stage is what remains.
   always_comb begin
      rs_fwd_sel = '0;
      rt_fwd_sel = '0;
      rs_value   = rf_rs_data;
      rt_value   = rf_rt_data;
      rs_stall_c = 1'b0;
      rt_stall_c = 1'b0;
      for (int i = int'(PIPE_DEPTH) - 1; i >= 0; i--) begin
         if (rs_req_c && ent_valid_q[i] && (ent_addr_q[i] == id_rs)) begin
            rs_fwd_sel = SEL_W'(i + 1);
            rs_value   = stage_result[i*DATA_WIDTH +: DATA_WIDTH];
            rs_stall_c = ent_load_q[i] && ((i + 1) < int'(LOAD_READY_STAGE));
         end
         if (rt_req_c && ent_valid_q[i] && (ent_addr_q[i] == id_rt)) begin
            rt_fwd_sel = SEL_W'(i + 1);
            rt_value   = stage_result[i*DATA_WIDTH +: DATA_WIDTH];
            rt_stall_c = ent_load_q[i] && ((i + 1) < int'(LOAD_READY_STAGE));
         end
      end
   end

   assign stall = rs_stall_c | rt_stall_c;

   // A stalled ID instruction leaves a bubble behind in stage 1.
   always_comb begin
      ent_valid_d = ent_valid_q;
      ent_addr_d  = ent_addr_q;
      ent_load_d  = ent_load_q;
      for (int i = int'(PIPE_DEPTH) - 1; i >= 1; i--) begin
         ent_valid_d[i] = ent_valid_q[i-1];
         ent_addr_d[i]  = ent_addr_q[i-1];
         ent_load_d[i]  = ent_load_q[i-1];
      end
      ent_valid_d[0] = id_valid && !stall && id_write_reg && (id_write_addr != '0);
      ent_addr_d[0]  = id_write_addr;
      ent_load_d[0]  = id_is_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid_q <= '0;
         ent_addr_q  <= '0;
         ent_load_q  <= '0;
      end else begin
         ent_valid_q <= ent_valid_d;
         ent_addr_q  <= ent_addr_d;
         ent_load_q  <= ent_load_d;
      end
   end

`ifdef ID_FORWARD_STATS_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] fwd_count_q,   fwd_count_d;
   logic [1:0]  fwd_inc_c;

   assign fwd_inc_c     = stall ? 2'd0
                                : ({1'b0, rs_fwd_sel != '0} + {1'b0, rt_fwd_sel != '0});
   assign stall_count_d = stall_count_q + 32'(stall);
   assign fwd_count_d   = fwd_count_q + 32'(fwd_inc_c);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_q <= '0;
         fwd_count_q   <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         fwd_count_q   <= fwd_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign fwd_count   = fwd_count_q;
`else
   assign stall_count = '0;
   assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// Bench for id_forward_scoreboard: default instance plus a PIPE_DEPTH=5 / LOAD_READY_STAGE=3 instance,
// both checked every cycle against an issue-history model.
module tb_id_forward_scoreboard;

   typedef struct packed {
      bit       v;
      bit [4:0] a;
      bit       ld;
   } rec_t;

   logic         clk;
   logic         rst;
   logic         id_valid, id_uses_rs, id_uses_rt, id_write_reg, id_is_load;
   logic [4:0]   id_rs, id_rt, id_write_addr;
   logic [31:0]  rf_rs, rf_rt;
   logic [95:0]  sr0;
   logic [159:0] sr1;

   logic         stall0, stall1;
   logic [31:0]  rs_v0, rt_v0, rs_v1, rt_v1;
   logic [1:0]   rs_sel0, rt_sel0;
   logic [2:0]   rs_sel1, rt_sel1;
   logic [31:0]  sc0, fc0, sc1, fc1;

   // h[d] = what entered the pipe d cycles ago (v=0 for bubbles / non-writers)
   rec_t         h0 [1:5];
   rec_t         h1 [1:5];
   bit           st0_m, st1_m;
   int           fw0_m, fw1_m;
   bit [31:0]    sc_m0, fc_m0, sc_m1, fc_m1;
   int           n_cmp, n_err;

   id_forward_scoreboard u0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rs(id_rs), .id_rt(id_rt), .id_write_reg(id_write_reg), .id_write_addr(id_write_addr),
      .id_is_load(id_is_load), .rf_rs_data(rf_rs), .rf_rt_data(rf_rt), .stage_result(sr0),
      .stall(stall0), .rs_value(rs_v0), .rt_value(rt_v0), .rs_fwd_sel(rs_sel0), .rt_fwd_sel(rt_sel0),
      .stall_count(sc0), .fwd_count(fc0)
   );

   id_forward_scoreboard #(.PIPE_DEPTH(5), .LOAD_READY_STAGE(3)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rs(id_rs), .id_rt(id_rt), .id_write_reg(id_write_reg), .id_write_addr(id_write_addr),
      .id_is_load(id_is_load), .rf_rs_data(rf_rs), .rf_rt_data(rf_rt), .stage_result(sr1),
      .stall(stall1), .rs_value(rs_v1), .rt_value(rt_v1), .rs_fwd_sel(rs_sel1), .rt_fwd_sel(rt_sel1),
      .stall_count(sc1), .fwd_count(fc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Most recent producer of src (distance in cycles), 0 if none applies.
   function automatic int youngest(input rec_t h [1:5], input int depth,
                                   input logic [4:0] src, input logic used);
      if (!id_valid || !used || src == 5'd0) return 0;
      for (int d = 1; d <= depth; d++)
         if (h[d].v && h[d].a == src) return d;
      return 0;
   endfunction

   function automatic bit not_ready(input rec_t h [1:5], input int d, input int lrs);
      if (d == 0) return 1'b0;
      return h[d].ld && (d < lrs);
   endfunction

   task automatic model_check();
      int  ks, kt;
      bit  st;
      logic [31:0] ev;
      // default instance
      ks = youngest(h0, 3, id_rs, id_uses_rs);
      kt = youngest(h0, 3, id_rt, id_uses_rt);
      st = not_ready(h0, ks, 2) || not_ready(h0, kt, 2);
      st0_m = st;
      fw0_m = st ? 0 : (int'(ks != 0) + int'(kt != 0));
      chk("u0.stall", 32'(stall0), 32'(st));
      if (!st) begin
         chk("u0.rs_sel", 32'(rs_sel0), 32'(ks));
         chk("u0.rt_sel", 32'(rt_sel0), 32'(kt));
         ev = (ks != 0) ? sr0[(ks-1)*32 +: 32] : rf_rs;
         chk("u0.rs_value", rs_v0, ev);
         ev = (kt != 0) ? sr0[(kt-1)*32 +: 32] : rf_rt;
         chk("u0.rt_value", rt_v0, ev);
      end
      // deep instance
      ks = youngest(h1, 5, id_rs, id_uses_rs);
      kt = youngest(h1, 5, id_rt, id_uses_rt);
      st = not_ready(h1, ks, 3) || not_ready(h1, kt, 3);
      st1_m = st;
      fw1_m = st ? 0 : (int'(ks != 0) + int'(kt != 0));
      chk("u1.stall", 32'(stall1), 32'(st));
      if (!st) begin
         chk("u1.rs_sel", 32'(rs_sel1), 32'(ks));
         chk("u1.rt_sel", 32'(rt_sel1), 32'(kt));
         ev = (ks != 0) ? sr1[(ks-1)*32 +: 32] : rf_rs;
         chk("u1.rs_value", rs_v1, ev);
         ev = (kt != 0) ? sr1[(kt-1)*32 +: 32] : rf_rt;
         chk("u1.rt_value", rt_v1, ev);
      end
`ifdef ID_FORWARD_STATS_EN
      chk("u0.stall_count", sc0, sc_m0);
      chk("u0.fwd_count",   fc0, fc_m0);
      chk("u1.stall_count", sc1, sc_m1);
      chk("u1.fwd_count",   fc1, fc_m1);
`else
      chk("u0.stall_count", sc0, 32'd0);
      chk("u0.fwd_count",   fc0, 32'd0);
      chk("u1.stall_count", sc1, 32'd0);
      chk("u1.fwd_count",   fc1, 32'd0);
`endif
   endtask

   task automatic model_clear();
      for (int d = 1; d <= 5; d++) begin
         h0[d] = '0;
         h1[d] = '0;
      end
      sc_m0 = '0; fc_m0 = '0; sc_m1 = '0; fc_m1 = '0;
   endtask

   task automatic model_advance();
      bit wr;
      @(posedge clk);
      wr = id_valid && id_write_reg && (id_write_addr != 5'd0);
      if (rst) begin
         model_clear();
      end else begin
         sc_m0 += 32'(st0_m);
         fc_m0 += 32'(fw0_m);
         sc_m1 += 32'(st1_m);
         fc_m1 += 32'(fw1_m);
         for (int d = 5; d >= 2; d--) begin
            h0[d] = h0[d-1];
            h1[d] = h1[d-1];
         end
         h0[1] = '{v: wr && !st0_m, a: id_write_addr, ld: id_is_load};
         h1[1] = '{v: wr && !st1_m, a: id_write_addr, ld: id_is_load};
      end
      #1;
   endtask

   task automatic set_id(input bit v, input bit ur, input bit ut, input logic [4:0] rs,
                         input logic [4:0] rt, input bit wr, input logic [4:0] wa, input bit ld);
      id_valid = v; id_uses_rs = ur; id_uses_rt = ut; id_rs = rs; id_rt = rt;
      id_write_reg = wr; id_write_addr = wa; id_is_load = ld;
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      model_advance();
   endtask

   task automatic reset_pulse();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      model_clear();
      st0_m = 0; st1_m = 0; fw0_m = 0; fw1_m = 0;

      // reset with stale ID inputs
      rst = 1'b1;
      set_id(1, 1, 1, 5, 6, 1, 5, 1);
      rf_rs = 32'h1234; rf_rt = 32'h0; sr0 = '0; sr1 = '0;
      @(posedge clk);
      model_clear();
      #1;
      @(negedge clk);
      model_check();
      chk("rst.stall", 32'(stall0), 32'd0);
      chk("rst.rs_sel", 32'(rs_sel0), 32'd0);
      chk("rst.rs_value", rs_v0, 32'h1234);
      chk("rst.stall_count", sc0, 32'd0);
      model_advance();
      rst = 1'b0;

      // ALU chain: add $3 then sub $4,$3,$1
      set_id(1, 1, 1, 1, 2, 1, 3, 0);
      rf_rs = 32'h11; rf_rt = 32'h22;
      step();
      set_id(1, 1, 1, 3, 1, 1, 4, 0);
      sr0[31:0] = 32'hAAAA; sr1[31:0] = 32'hAAAA;
      @(negedge clk);
      model_check();
      chk("alu.stall", 32'(stall0), 32'd0);
      chk("alu.rs_sel", 32'(rs_sel0), 32'd1);
      chk("alu.rs_value", rs_v0, 32'hAAAA);
      model_advance();

      // load-use: lw $5 then add $6,$5,$5 held in ID
      reset_pulse();
      set_id(1, 1, 0, 2, 0, 1, 5, 1);
      step();
      set_id(1, 1, 1, 5, 5, 1, 6, 0);
      sr0[63:32] = 32'hDEAD0001; sr1[95:64] = 32'hDEAD0001;
      @(negedge clk);
      model_check();
      chk("lu.c1.stall", 32'(stall0), 32'd1);
      chk("lu.c1.stall_deep", 32'(stall1), 32'd1);
      model_advance();
      @(negedge clk);
      model_check();
      chk("lu.c2.stall", 32'(stall0), 32'd0);
      chk("lu.c2.rs_sel", 32'(rs_sel0), 32'd2);
      chk("lu.c2.rt_sel", 32'(rt_sel0), 32'd2);
      chk("lu.c2.rs_value", rs_v0, 32'hDEAD0001);
      chk("lu.c2.rt_value", rt_v0, 32'hDEAD0001);
      chk("lu.c2.stall_deep", 32'(stall1), 32'd1);
      model_advance();
      @(negedge clk);
      model_check();
      chk("lu.c3.stall_deep", 32'(stall1), 32'd0);
      chk("lu.c3.rs_sel_deep", 32'(rs_sel1), 32'd3);
      chk("lu.c3.rs_value_deep", rs_v1, 32'hDEAD0001);
`ifdef ID_FORWARD_STATS_EN
      chk("lu.stall_count", sc0, 32'd1);
      chk("lu.fwd_count", fc0, 32'd2);
`else
      chk("lu.stall_count", sc0, 32'd0);
      chk("lu.fwd_count", fc0, 32'd0);
`endif
      model_advance();

      // distance-3 load dependency: no stall on the deep instance
      reset_pulse();
      set_id(1, 1, 0, 1, 0, 1, 9, 1);
      step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      set_id(1, 1, 0, 9, 0, 1, 10, 0);
      sr1[95:64] = 32'h9999;
      @(negedge clk);
      model_check();
      chk("d3.stall_deep", 32'(stall1), 32'd0);
      chk("d3.rs_sel_deep", 32'(rs_sel1), 32'd3);
      chk("d3.rs_value_deep", rs_v1, 32'h9999);
      model_advance();

      // priority: $7 written in stages 3 and 1
      reset_pulse();
      set_id(1, 1, 1, 1, 2, 1, 7, 0); step();
      set_id(1, 1, 1, 1, 2, 1, 8, 0); step();
      set_id(1, 1, 1, 1, 2, 1, 7, 0); step();
      set_id(1, 1, 0, 7, 0, 1, 11, 0);
      sr0 = {32'h3, 32'h2, 32'h1};
      @(negedge clk);
      model_check();
      chk("prio.rs_sel", 32'(rs_sel0), 32'd1);
      chk("prio.rs_value", rs_v0, 32'h1);
      model_advance();

      // register zero: load writing $0, then reader of $0
      set_id(1, 1, 0, 1, 0, 1, 0, 1); step();
      set_id(1, 1, 1, 0, 0, 1, 12, 0);
      rf_rs = 32'h0; rf_rt = 32'h0;
      @(negedge clk);
      model_check();
      chk("r0.stall", 32'(stall0), 32'd0);
      chk("r0.rs_sel", 32'(rs_sel0), 32'd0);
      chk("r0.rs_value", rs_v0, 32'h0);
      model_advance();

      // reset in the middle of a stall releases it next cycle
      reset_pulse();
      set_id(1, 1, 0, 2, 0, 1, 5, 1); step();
      set_id(1, 1, 1, 5, 5, 1, 6, 0);
      @(negedge clk);
      model_check();
      chk("rms.stall_before", 32'(stall0), 32'd1);
      rst = 1'b1;
      model_advance();
      rst = 1'b0;
      @(negedge clk);
      model_check();
      chk("rms.stall_after", 32'(stall0), 32'd0);
      model_advance();

      // randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         set_id($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
         rf_rs = $urandom; rf_rt = $urandom;
         for (int s = 0; s < 3; s++) sr0[s*32 +: 32] = $urandom;
         for (int s = 0; s < 5; s++) sr1[s*32 +: 32] = $urandom;
         rst = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
